alt_vipitc131_is2vid_sync_apply: RTL and testbench
==================================================

# alt_vipitc131_IS2Vid_sync_apply

Output-side genlock actuator for the IS2Vid clocked video output. It owns the CVO frame timing counters and produces `sof_cvo`/`sof_cvo_locked`, which feed the sync-compare block. It consumes that block's correction outputs: it removes samples and lines by jumping the counters forward, or repeats them by stalling at the frame boundary. Together these pull the output frame into phase with the input frame.

## Interface
Parameters:
- GUARD_FRAMES, 2: frame ends after an applied correction during which further corrections are ignored (1..15).

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  counter advance qualifier (one sample per enabled cycle)
- restart_count  in  1  synchronous clear of counters, FSM, guard and lock
- h_total_minus_one  in  14  samples per line minus one
- v_total_minus_one  in  13  lines per frame minus one
- sync_lines  in  1  line offset valid
- sync_samples  in  1  sample offset valid
- remove_repeatn  in  1  1 = remove (jump ahead), 0 = repeat (stall)
- sync_compare_h_reset  in  13  sample offset
- sync_compare_v_reset  in  13  line offset
- genlocked  in  1  compare reports phase within tolerance
- h_count  out  14  current sample position
- v_count  out  13  current line position
- sof_cvo  out  1  one-cycle start-of-frame pulse
- sof_cvo_locked  out  1  output timing is running and stable
- repeating  out  1  high while the block is in REPEAT
- correction_applied  out  1  one-cycle pulse when a correction is taken
- genlocked_out  out  1  registered lock status

## Operation
- States: RUN, REPEAT. Reset, or `restart_count`, forces RUN, counters (0,0), guard=0, every output 0.
- RUN, enable=1: h increments; at h==h_total_minus_one, h goes to 0 and v increments; `frame_end` = (h==h_total_minus_one && v==v_total_minus_one).
- Offsets at frame_end:
  - eff_v = sync_lines ? sync_compare_v_reset : 0.
  - eff_h = (sync_lines|sync_samples) ? sync_compare_h_reset : 0.
  - A correction is pending if guard==0 and (eff_v|eff_h)!=0.
- frame_end, no correction: counters go to (0,0) and `sof_cvo` is asserted. If guard>0, guard decrements.
- frame_end with a correction and remove_repeatn=1:
  - Counters load (min(eff_v, v_total_minus_one), min(eff_h, h_total_minus_one)), zero-extended.
  - `sof_cvo` and `correction_applied` are asserted, and guard loads GUARD_FRAMES.
- frame_end with a correction and remove_repeatn=0:
  - Latch eff_v and eff_h into rep_v and rep_h, clear the repeat counters (rv, rh), and enter REPEAT.
  - `correction_applied` is asserted, and guard loads GUARD_FRAMES.
- REPEAT:
  - h_count and v_count hold their frame_end values, and `repeating`=1.
  - Each enabled cycle, rh/rv count in the same nested way as h/v, with rh wrapping at h_total_minus_one.
  - When (rv,rh) reaches (rep_v,rep_h), the next enabled cycle loads counters (0,0), asserts `sof_cvo` and returns to RUN.
  - Repeat length = rep_v*(h_total_minus_one+1)+rep_h+1 enabled cycles beyond the normal wrap. rep_h is clamped to h_total_minus_one.
- Inputs are sampled only on the frame_end cycle; changes at other times are ignored.
- `sof_cvo_locked` sets on the first `sof_cvo` after reset or restart. It clears only on rst or restart_count.
- `genlocked_out` updates at each frame_end to (genlocked && no correction taken).

## Timing
- All outputs are registered. Counters, `sof_cvo`, `correction_applied` and `repeating` change on the clock edge after the qualifying enabled cycle.
- `sof_cvo` is high in exactly the cycle in which the new frame's first counter values are presented.
- With enable=0, nothing advances and pulse outputs are 0.
- With totals of 0 (1×1 frame), every enabled cycle is a frame_end.
- Guard decrements only on frame_end and saturates at 0.
- restart_count during REPEAT aborts immediately to RUN (0,0) with no `sof_cvo`.

## Test plan
- h_total_minus_one=9, v_total_minus_one=4, enable=1, no sync → `sof_cvo` every 50 cycles; the counter sequence wraps 9→0 and 4→0.
- At frame_end: sync_samples=1, remove=1, h_reset=3 → next values (0,3), `sof_cvo` and `correction_applied` pulse, next frame is 47 cycles.
- sync_lines=1, v_reset=1, h_reset=2, remove=0 → repeating=1 for 13 cycles with counters held at (4,9), then (0,0) with `sof_cvo`; sof-to-sof = 63.
- Request held constant with GUARD_FRAMES=2 → corrected frame, two uncorrected 50-cycle frames, then the correction applies again.
- Remove with h_reset=20 and v_reset=9 → clamps to (4,9), so the next cycle is a frame_end again.
- Assert rst asynchronously mid-REPEAT → all outputs 0 immediately. After release, the first `sof_cvo` arrives 50 cycles later and `sof_cvo_locked` sets with it.

Source files
------------

// File: rtl/alt_vipitc131_is2vid_sync_apply.sv
// Output-side genlock actuator for the IS2Vid clocked video output.
// Owns the CVO frame timing counters and applies phase corrections from the
// sync-compare block at the frame boundary: a "remove" correction jumps the
// counters forward, a "repeat" correction stalls at the boundary for a
// programmed number of samples before starting the next frame.
//
// Handshake note: there is no valid/ready pair here. Correction requests are
// level inputs that are sampled only on the enabled frame_end cycle; enable
// qualifies every advance, and all outputs are registered.
module alt_vipitc131_is2vid_sync_apply #(
    parameter int GUARD_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        restart_count,
    input  logic [13:0] h_total_minus_one,
    input  logic [12:0] v_total_minus_one,
    input  logic        sync_lines,
    input  logic        sync_samples,
    input  logic        remove_repeatn,
    input  logic [12:0] sync_compare_h_reset,
    input  logic [12:0] sync_compare_v_reset,
    input  logic        genlocked,
    output logic [13:0] h_count,
    output logic [12:0] v_count,
    output logic        sof_cvo,
    output logic        sof_cvo_locked,
    output logic        repeating,
    output logic        correction_applied,
    output logic        genlocked_out
);

    typedef enum logic {
        RUN    = 1'b0,
        REPEAT = 1'b1
    } state_t;

    state_t      state, state_n;

    // Repeat progress counters and the latched repeat target.
    logic [13:0] rh, rh_n;
    logic [12:0] rv, rv_n;
    logic [13:0] rep_h, rep_h_n;
    logic [12:0] rep_v, rep_v_n;
    logic [3:0]  guard, guard_n;

    logic [13:0] h_n;
    logic [12:0] v_n;
    logic        sof_n;
    logic        corr_n;
    logic        locked_n;
    logic        repeating_n;
    logic        gl_n;

    // Correction decode, meaningful on the frame_end cycle only.
    logic        at_frame_end;
    logic [12:0] eff_v;
    logic [12:0] eff_h;
    logic [13:0] eff_h_ext;
    logic [13:0] clamp_h;
    logic [12:0] clamp_v;
    logic        corr_pending;
    logic        rep_last;

    // Offset selection, clamping and end-of-frame / end-of-repeat detection.
    always_comb begin
        at_frame_end = (h_count == h_total_minus_one) && (v_count == v_total_minus_one);
        eff_v        = sync_lines ? sync_compare_v_reset : 13'd0;
        eff_h        = (sync_lines | sync_samples) ? sync_compare_h_reset : 13'd0;
        eff_h_ext    = {1'b0, eff_h};
        clamp_h      = (eff_h_ext > h_total_minus_one) ? h_total_minus_one : eff_h_ext;
        clamp_v      = (eff_v > v_total_minus_one) ? v_total_minus_one : eff_v;
        corr_pending = (guard == 4'd0) && ((eff_v != 13'd0) || (eff_h != 13'd0));
        rep_last     = (rv == rep_v) && (rh == rep_h);
    end

    // Next-state and next-output logic for the RUN/REPEAT machine.
    always_comb begin
        state_n  = state;
        h_n      = h_count;
        v_n      = v_count;
        rh_n     = rh;
        rv_n     = rv;
        rep_h_n  = rep_h;
        rep_v_n  = rep_v;
        guard_n  = guard;
        sof_n    = 1'b0;
        corr_n   = 1'b0;
        gl_n     = genlocked_out;

        if (restart_count) begin
            state_n = RUN;
            h_n     = 14'd0;
            v_n     = 13'd0;
            rh_n    = 14'd0;
            rv_n    = 13'd0;
            rep_h_n = 14'd0;
            rep_v_n = 13'd0;
            guard_n = 4'd0;
            gl_n    = 1'b0;
        end else if (enable) begin
            case (state)
                RUN: begin
                    if (at_frame_end) begin
                        if (corr_pending) begin
                            guard_n = 4'(GUARD_FRAMES);
                            corr_n  = 1'b1;
                            gl_n    = 1'b0;
                            if (remove_repeatn) begin
                                // Jump ahead: the new frame starts part-way in.
                                h_n   = clamp_h;
                                v_n   = clamp_v;
                                sof_n = 1'b1;
                            end else begin
                                // Stall: counters hold at the frame_end position.
                                rep_h_n = clamp_h;
                                rep_v_n = eff_v;
                                rh_n    = 14'd0;
                                rv_n    = 13'd0;
                                state_n = REPEAT;
                            end
                        end else begin
                            h_n   = 14'd0;
                            v_n   = 13'd0;
                            sof_n = 1'b1;
                            gl_n  = genlocked;
                            if (guard != 4'd0) begin
                                guard_n = guard - 4'd1;
                            end
                        end
                    end else if (h_count == h_total_minus_one) begin
                        h_n = 14'd0;
                        v_n = v_count + 13'd1;
                    end else begin
                        h_n = h_count + 14'd1;
                    end
                end
                REPEAT: begin
                    if (rep_last) begin
                        h_n     = 14'd0;
                        v_n     = 13'd0;
                        sof_n   = 1'b1;
                        state_n = RUN;
                    end else if (rh == h_total_minus_one) begin
                        rh_n = 14'd0;
                        rv_n = rv + 13'd1;
                    end else begin
                        rh_n = rh + 14'd1;
                    end
                end
                default: state_n = RUN;
            endcase
        end

        locked_n    = restart_count ? 1'b0 : (sof_cvo_locked | sof_n);
        repeating_n = (state_n == REPEAT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= RUN;
            h_count            <= 14'd0;
            v_count            <= 13'd0;
            rh                 <= 14'd0;
            rv                 <= 13'd0;
            rep_h              <= 14'd0;
            rep_v              <= 13'd0;
            guard              <= 4'd0;
            sof_cvo            <= 1'b0;
            sof_cvo_locked     <= 1'b0;
            repeating          <= 1'b0;
            correction_applied <= 1'b0;
            genlocked_out      <= 1'b0;
        end else begin
            state              <= state_n;
            h_count            <= h_n;
            v_count            <= v_n;
            rh                 <= rh_n;
            rv                 <= rv_n;
            rep_h              <= rep_h_n;
            rep_v              <= rep_v_n;
            guard              <= guard_n;
            sof_cvo            <= sof_n;
            sof_cvo_locked     <= locked_n;
            repeating          <= repeating_n;
            correction_applied <= corr_n;
            genlocked_out      <= gl_n;
        end
    end

endmodule

// File: tb/tb_alt_vipitc131_is2vid_sync_apply.sv
// Self-checking bench for alt_vipitc131_is2vid_sync_apply.
// The driver issues directed correction requests and pushes the expected
// start-of-frame event for each into exp_q; the monitor pops and compares
// one entry on every sof_cvo pulse (frame length, counter load, repeat
// length, correction pulses, genlock status).
module tb_alt_vipitc131_is2vid_sync_apply;

    localparam int W = 54;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        restart_count;
    logic [13:0] h_total_minus_one;
    logic [12:0] v_total_minus_one;
    logic        sync_lines;
    logic        sync_samples;
    logic        remove_repeatn;
    logic [12:0] sync_compare_h_reset;
    logic [12:0] sync_compare_v_reset;
    logic        genlocked;
    logic [13:0] h_count;
    logic [12:0] v_count;
    logic        sof_cvo;
    logic        sof_cvo_locked;
    logic        repeating;
    logic        correction_applied;
    logic        genlocked_out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Clock and reset block.
    always #5 clk = ~clk;

    alt_vipitc131_is2vid_sync_apply #(.GUARD_FRAMES(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .restart_count        (restart_count),
        .h_total_minus_one    (h_total_minus_one),
        .v_total_minus_one    (v_total_minus_one),
        .sync_lines           (sync_lines),
        .sync_samples         (sync_samples),
        .remove_repeatn       (remove_repeatn),
        .sync_compare_h_reset (sync_compare_h_reset),
        .sync_compare_v_reset (sync_compare_v_reset),
        .genlocked            (genlocked),
        .h_count              (h_count),
        .v_count              (v_count),
        .sof_cvo              (sof_cvo),
        .sof_cvo_locked       (sof_cvo_locked),
        .repeating            (repeating),
        .correction_applied   (correction_applied),
        .genlocked_out        (genlocked_out)
    );

    // Event record: {delta, h, v, repeat cycles, correction pulses, genlocked_out}.
    function automatic logic [W-1:0] pack(int delta, int h, int v, int rep, int corr, int gl);
        pack = {16'(delta), 14'(h), 13'(v), 8'(rep), 2'(corr), 1'(gl)};
    endfunction

    task automatic show_fail(string tag, int idx, logic [W-1:0] got, logic [W-1:0] exp);
        $display("FAIL %s[%0d] got delta=%0d h=%0d v=%0d rep=%0d corr=%0d gl=%0d expected delta=%0d h=%0d v=%0d rep=%0d corr=%0d gl=%0d",
                 tag, idx, got[53:38], got[37:24], got[23:11], got[10:3], got[2:1], got[0],
                 exp[53:38], exp[37:24], exp[23:11], exp[10:3], exp[2:1], exp[0]);
    endtask

    task automatic check(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_idle(string tag);
        check({tag, "_h_count"}, int'(h_count), 0);
        check({tag, "_v_count"}, int'(v_count), 0);
        check({tag, "_sof_cvo"}, int'(sof_cvo), 0);
        check({tag, "_sof_cvo_locked"}, int'(sof_cvo_locked), 0);
        check({tag, "_repeating"}, int'(repeating), 0);
        check({tag, "_correction_applied"}, int'(correction_applied), 0);
        check({tag, "_genlocked_out"}, int'(genlocked_out), 0);
    endtask

    // Driver tasks.
    task automatic expect_sof(int delta, int h, int v, int rep, int corr, int gl);
        exp_q.push_back(pack(delta, h, v, rep, corr, gl));
    endtask

    task automatic set_sync(logic lines, logic samples, logic remove, int vr, int hr);
        sync_lines           = lines;
        sync_samples         = samples;
        remove_repeatn       = remove;
        sync_compare_v_reset = 13'(vr);
        sync_compare_h_reset = 13'(hr);
    endtask

    task automatic wait_sof(string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (sof_cvo) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_sof_%s got=timeout expected=sof_cvo within 200 cycles", tag);
        end
    endtask

    task automatic wait_rep(string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (repeating) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_rep_%s got=timeout expected=repeating within 200 cycles", tag);
        end
    endtask

    // Monitor / scoreboard: measures each frame and compares on sof_cvo.
    initial begin
        int cyc      = 0;
        int last_sof = 0;
        int rep_cnt  = 0;
        int corr_cnt = 0;
        int sof_idx  = 0;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst || restart_count) begin
                last_sof = cyc;
                rep_cnt  = 0;
                corr_cnt = 0;
            end else begin
                if (repeating) rep_cnt++;
                if (correction_applied) corr_cnt++;
                if (sof_cvo) begin
                    got = pack(cyc - last_sof, int'(h_count), int'(v_count), rep_cnt, corr_cnt,
                               int'(genlocked_out));
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sof_unexpected[%0d] got delta=%0d h=%0d v=%0d expected=no sof_cvo",
                                 sof_idx, cyc - last_sof, h_count, v_count);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            show_fail("sof_event", sof_idx, got, exp);
                        end
                    end
                    check("sof_locked", int'(sof_cvo_locked), 1);
                    last_sof = cyc;
                    rep_cnt  = 0;
                    corr_cnt = 0;
                    sof_idx++;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        rst               = 1'b1;
        enable            = 1'b1;
        restart_count     = 1'b0;
        h_total_minus_one = 14'd9;
        v_total_minus_one = 13'd4;
        genlocked         = 1'b1;
        set_sync(1'b0, 1'b0, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        check_idle("reset");

        // Plain 10x5 frames.
        expect_sof(50, 0, 0, 0, 0, 1);
        rst = 1'b0;
        wait_sof("first");

        // Remove h=3: corrected sof lands at (0,3), following frame is 47.
        @(negedge clk);
        set_sync(1'b0, 1'b1, 1'b1, 0, 3);
        expect_sof(50, 3, 0, 0, 1, 0);
        wait_sof("remove");
        @(negedge clk);
        set_sync(1'b0, 1'b0, 1'b0, 0, 0);
        expect_sof(47, 0, 0, 0, 0, 1);
        wait_sof("after_remove");
        expect_sof(50, 0, 0, 0, 0, 1);
        wait_sof("guard_drain1");

        // Repeat v=1 h=2: 13 stalled cycles, sof-to-sof 63.
        @(negedge clk);
        set_sync(1'b1, 1'b0, 1'b0, 1, 2);
        expect_sof(63, 0, 0, 13, 1, 0);
        wait_sof("repeat");

        // Held remove request: guard blocks two frame ends, then it reapplies.
        @(negedge clk);
        set_sync(1'b0, 1'b1, 1'b1, 0, 3);
        expect_sof(50, 0, 0, 0, 0, 1);
        expect_sof(50, 0, 0, 0, 0, 1);
        expect_sof(50, 3, 0, 0, 1, 0);
        expect_sof(47, 0, 0, 0, 0, 1);
        expect_sof(50, 0, 0, 0, 0, 1);
        expect_sof(50, 3, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) wait_sof("guard_hold");
        @(negedge clk);
        set_sync(1'b0, 1'b0, 1'b0, 0, 0);
        expect_sof(47, 0, 0, 0, 0, 1);
        expect_sof(50, 0, 0, 0, 0, 1);
        wait_sof("guard_drain2");
        wait_sof("guard_drain3");

        // Oversized remove clamps to (4,9): the very next cycle is a frame end.
        @(negedge clk);
        set_sync(1'b1, 1'b0, 1'b1, 9, 20);
        expect_sof(50, 9, 4, 0, 1, 0);
        expect_sof(1, 0, 0, 0, 0, 1);
        wait_sof("clamp");
        @(negedge clk);
        set_sync(1'b0, 1'b0, 1'b0, 0, 0);
        wait_sof("clamp_next");
        expect_sof(50, 0, 0, 0, 0, 1);
        wait_sof("guard_drain4");

        // Asynchronous reset in the middle of a repeat.
        @(negedge clk);
        set_sync(1'b1, 1'b0, 1'b0, 1, 2);
        wait_rep("async");
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        set_sync(1'b0, 1'b0, 1'b0, 0, 0);
        expect_sof(50, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        wait_sof("after_rst");

        // restart_count in the middle of a repeat: abort to (0,0), no sof.
        @(negedge clk);
        set_sync(1'b1, 1'b0, 1'b0, 1, 2);
        wait_rep("restart");
        repeat (3) @(negedge clk);
        restart_count = 1'b1;
        set_sync(1'b0, 1'b0, 1'b0, 0, 0);
        expect_sof(50, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        check_idle("restart");
        @(negedge clk);
        restart_count = 1'b0;
        wait_sof("after_restart");

        // Enable low for 5 cycles stretches the frame to 55 cycles.
        expect_sof(55, 0, 0, 0, 0, 1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        wait_sof("enable_gap");

        // 1x1 frame: every enabled cycle is a frame end.
        @(negedge clk);
        restart_count     = 1'b1;
        h_total_minus_one = 14'd0;
        v_total_minus_one = 13'd0;
        for (int i = 0; i < 4; i++) expect_sof(1, 0, 0, 0, 0, 1);
        @(negedge clk);
        restart_count = 1'b0;
        for (int i = 0; i < 4; i++) wait_sof("one_by_one");
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
